// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between a 6502-style CPU and a DMA engine.
// Each access runs through IDLE -> LOAD -> [WAIT] -> COMPLETE, with wait states
// picked from the address decode that comes back for the registered bus_addr.
// DMA wins when the CPU is idle or after DMA_MAX_WAIT back-to-back CPU grants.
module mem_arbiter #(
  parameter int SDRAM_WAIT   = 2,
  parameter int ROM_WAIT     = 1,
  parameter int IO_WAIT      = 0,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic        dma_we,
  output logic        dma_gnt,
  output logic        dma_done,
  input  logic        sdram_cs,
  input  logic        rom_cs,
  output logic [15:0] bus_addr,
  output logic        bus_we,
  output logic        bus_sel,
  output logic        bus_active,
  output logic        bus_strobe
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, COMPLETE} state_t;

  localparam logic [7:0] SDRAM_W = 8'(SDRAM_WAIT);
  localparam logic [7:0] ROM_W   = 8'(ROM_WAIT);
  localparam logic [7:0] IO_W    = 8'(IO_WAIT);
  localparam logic [4:0] DMA_MAX = 5'(DMA_MAX_WAIT);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic [7:0]  load_val;
  logic [3:0]  starve_cnt, starve_nxt;
  logic        grant_cpu, grant_dma;

  // Wait-state selection from the decoder; SDRAM wins if both selects are high
  always_comb begin
    load_val = IO_W;
    if (sdram_cs)    load_val = SDRAM_W;
    else if (rom_cs) load_val = ROM_W;
  end

  // Next-state, grant decision and wait counter update
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    case (state)
      IDLE: begin
        if (dma_req && (!cpu_req || ({1'b0, starve_cnt} >= DMA_MAX))) begin
          grant_dma = 1'b1;
          state_nxt = LOAD;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        wait_nxt  = load_val;
        state_nxt = (load_val == 8'd0) ? COMPLETE : WAIT;
      end
      WAIT: begin
        if (wait_cnt == 8'd1) begin
          wait_nxt  = 8'd0;
          state_nxt = COMPLETE;
        end else begin
          wait_nxt  = wait_cnt - 8'd1;
        end
      end
      COMPLETE: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Starvation counter: counts CPU grants taken while DMA is waiting
  always_comb begin
    starve_nxt = starve_cnt;
    if (!dma_req || grant_dma)          starve_nxt = 4'd0;
    else if (grant_cpu && starve_cnt != 4'hf) starve_nxt = starve_cnt + 4'd1;
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 8'd0;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Bus owner, address and direction captured only at grant, held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_addr <= 16'd0;
      bus_we   <= 1'b0;
      bus_sel  <= 1'b0;
    end else if (grant_dma) begin
      bus_addr <= dma_addr;
      bus_we   <= dma_we;
      bus_sel  <= 1'b1;
    end else if (grant_cpu) begin
      bus_addr <= cpu_addr;
      bus_we   <= cpu_we;
      bus_sel  <= 1'b0;
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    bus_active = (state != IDLE);
    bus_strobe = (state == COMPLETE);
    dma_gnt    = bus_active && bus_sel;
    dma_done   = bus_strobe && bus_sel;
    cpu_rdy    = !cpu_req || (bus_strobe && !bus_sel);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized bench for mem_arbiter against a transaction-level model.
// The model tracks each access as "granted at some cycle, lasting W+2 cycles".
module tb_mem_arbiter;

  localparam int SDRAM_WAIT   = 2;
  localparam int ROM_WAIT     = 1;
  localparam int IO_WAIT      = 0;
  localparam int DMA_MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic        cpu_rdy, dma_gnt, dma_done;
  logic        sdram_cs, rom_cs;
  logic [15:0] bus_addr;
  logic        bus_we, bus_sel, bus_active, bus_strobe;

  int checks = 0;
  int errors = 0;

  // Model state
  bit          m_busy;
  int          m_k;
  int          m_w;
  bit          m_owner;
  logic [15:0] m_addr;
  bit          m_we;
  int          m_starve;
  int          n_strobe, n_done;

  always #5 clk = ~clk;

  // Address decoder: 0x0000-0x0FFF raises both selects (SDRAM must win)
  assign sdram_cs = (bus_addr < 16'h7000);
  assign rom_cs   = (bus_addr >= 16'h8000) || (bus_addr < 16'h1000);

  mem_arbiter #(
    .SDRAM_WAIT(SDRAM_WAIT), .ROM_WAIT(ROM_WAIT),
    .IO_WAIT(IO_WAIT), .DMA_MAX_WAIT(DMA_MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we),
    .dma_gnt(dma_gnt), .dma_done(dma_done),
    .sdram_cs(sdram_cs), .rom_cs(rom_cs),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_active(bus_active), .bus_strobe(bus_strobe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int wait_of(input logic [15:0] a);
    if (a < 16'h7000)       return SDRAM_WAIT;
    else if (a >= 16'h8000) return ROM_WAIT;
    else                    return IO_WAIT;
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(16'h0000, 16'h0fff));
      1:       return 16'($urandom_range(16'h1000, 16'h6fff));
      2:       return 16'($urandom_range(16'h7000, 16'h7fff));
      default: return 16'($urandom_range(16'h8000, 16'hffff));
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_w = 0; m_owner = 0;
    m_addr = 16'h0; m_we = 0; m_starve = 0;
  endtask

  // Compare every DUT output with what the model says for this cycle
  task automatic check_outputs();
    bit fin;
    fin = m_busy && (m_k == m_w + 2);
    chk("bus_active", 32'(bus_active), 32'(m_busy));
    chk("bus_strobe", 32'(bus_strobe), 32'(fin));
    chk("dma_gnt",    32'(dma_gnt),    32'(m_busy && m_owner));
    chk("dma_done",   32'(dma_done),   32'(fin && m_owner));
    chk("cpu_rdy",    32'(cpu_rdy),    32'(!cpu_req || (fin && !m_owner)));
    chk("bus_addr",   32'(bus_addr),   32'(m_addr));
    chk("bus_we",     32'(bus_we),     32'(m_we));
    chk("bus_sel",    32'(bus_sel),    32'(m_owner));
    if (fin) n_strobe++;
    if (fin && m_owner) n_done++;
  endtask

  // Advance the model across one rising edge using the inputs now applied
  task automatic model_step();
    bit gd, gc;
    gd = 0; gc = 0;
    if (!m_busy) begin
      gd = dma_req && (!cpu_req || m_starve >= DMA_MAX_WAIT);
      gc = !gd && cpu_req;
    end
    if (!dma_req || gd) m_starve = 0;
    else if (gc)        m_starve = (m_starve >= 15) ? 15 : m_starve + 1;
    if (m_busy) begin
      if (m_k == m_w + 2) m_busy = 0;
      else                m_k++;
    end else if (gd || gc) begin
      m_busy  = 1;
      m_k     = 1;
      m_owner = gd;
      m_addr  = gd ? dma_addr : cpu_addr;
      m_we    = gd ? dma_we : cpu_we;
      m_w     = wait_of(m_addr);
    end
  endtask

  // mode 0: random mix, 1: both requests held, 2: DMA only
  task automatic run_cycle(input int mode, input bit do_rst);
    @(negedge clk);
    cpu_addr = rand_addr();
    dma_addr = rand_addr();
    cpu_we   = 1'($urandom_range(0, 1));
    dma_we   = 1'($urandom_range(0, 1));
    case (mode)
      1:       begin cpu_req = 1'b1; dma_req = 1'b1; end
      2:       begin cpu_req = 1'b0; dma_req = ($urandom_range(0, 9) < 7); end
      default: begin cpu_req = ($urandom_range(0, 9) < 7); dma_req = ($urandom_range(0, 9) < 4); end
    endcase
    #1;
    check_outputs();
    if (do_rst) begin
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      #1 rst_n = 1'b1;
    end
    model_step();
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0;
    dma_req = 0; dma_we = 0; dma_addr = 16'h0;
    n_strobe = 0; n_done = 0;
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) run_cycle(0, $urandom_range(0, 49) == 0);
    for (int i = 0; i < 200; i++)  run_cycle(1, 1'b0);
    for (int i = 0; i < 150; i++)  run_cycle(2, $urandom_range(0, 59) == 0);
    for (int i = 0; i < 500; i++)  run_cycle(0, $urandom_range(0, 29) == 0);

    chk("strobes_seen", 32'(n_strobe > 0), 32'd1);
    chk("dma_done_seen", 32'(n_done > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
